// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler: shares one combinational fpu between the CPU FP pipeline
// (port 0) and the neuron-update engine (port 1). A round-robin winner's
// operands are latched onto the fpu inputs and held for a per-op latency.
// After that latency the fpu result is captured and returned to the owning
// port.
//
// Handshake (both request and response sides): a transfer happens on a rising
// edge where VALID and READY are both high. The producer holds VALID and
// payload stable until that edge. REQn_READY is combinational and is high only
// in IDLE, only for the granted port, and never while RESET is high.
// RESPn_VALID is registered and stays high, with RESP_RESULT stable, until the
// owner's RESPn_READY is seen.
//
// Every LAT_* parameter must lie in 1..15 (4-bit latency counter).
module fpu_op_scheduler #(
  parameter int LAT_BASIC = 1,
  parameter int LAT_MUL   = 3,
  parameter int LAT_DIV   = 8,
  parameter int LAT_FUSED = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [31:0] REQ0_DATA1,
  input  logic [31:0] REQ0_DATA2,
  input  logic [31:0] REQ0_DATA3,
  input  logic [4:0]  REQ0_SELECT,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [31:0] REQ1_DATA1,
  input  logic [31:0] REQ1_DATA2,
  input  logic [31:0] REQ1_DATA3,
  input  logic [4:0]  REQ1_SELECT,
  output logic        RESP0_VALID,
  input  logic        RESP0_READY,
  output logic        RESP1_VALID,
  input  logic        RESP1_READY,
  output logic [31:0] RESP_RESULT,
  output logic [31:0] FPU_DATA1,
  output logic [31:0] FPU_DATA2,
  output logic [31:0] FPU_DATA3,
  output logic [4:0]  FPU_SELECT,
  input  logic [31:0] FPU_RESULT,
  output logic        BUSY,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        ptr;
  logic        owner;
  logic [3:0]  cnt;

  logic        grant1;
  logic        accept;
  logic [31:0] d1_in;
  logic [31:0] d2_in;
  logic [31:0] d3_in;
  logic [4:0]  sel_in;

  // Latency budget for an op code; undefined codes fall into the basic class.
  function automatic logic [3:0] lat_of(input logic [4:0] sel);
    logic [3:0] lat;
    lat = 4'(LAT_BASIC);
    if (sel == 5'b00011)
      lat = 4'(LAT_MUL);
    else if (sel == 5'b00100)
      lat = 4'(LAT_DIV);
    else if (sel >= 5'b01110 && sel <= 5'b10001)
      lat = 4'(LAT_FUSED);
    return lat;
  endfunction

  // Round-robin grant and request-side READY; reset blocks any accept.
  always_comb begin
    grant1     = REQ1_VALID & (~REQ0_VALID | ptr);
    accept     = ~RESET & (state == IDLE) & (REQ0_VALID | REQ1_VALID);
    REQ0_READY = accept & ~grant1;
    REQ1_READY = accept & grant1;
    d1_in      = grant1 ? REQ1_DATA1  : REQ0_DATA1;
    d2_in      = grant1 ? REQ1_DATA2  : REQ0_DATA2;
    d3_in      = grant1 ? REQ1_DATA3  : REQ0_DATA3;
    sel_in     = grant1 ? REQ1_SELECT : REQ0_SELECT;
  end

  // Scheduler FSM: latch winner, count down latency, capture, hand back.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      cnt         <= 4'd0;
      RESP_RESULT <= 32'd0;
      FPU_DATA1   <= 32'd0;
      FPU_DATA2   <= 32'd0;
      FPU_DATA3   <= 32'd0;
      FPU_SELECT  <= 5'd0;
      RESP0_VALID <= 1'b0;
      RESP1_VALID <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant1;
            FPU_DATA1  <= d1_in;
            FPU_DATA2  <= d2_in;
            FPU_DATA3  <= d3_in;
            FPU_SELECT <= sel_in;
            cnt        <= lat_of(sel_in) - 4'd1;
            BUSY       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // FPU_* regs are untouched here so the fpu paths see stable inputs.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            RESP_RESULT <= FPU_RESULT;
            RESP0_VALID <= ~owner;
            RESP1_VALID <= owner;
            state       <= DONE;
          end
        end
        DONE: begin
          // Only the owner's READY completes the op; the other is ignored.
          if (owner ? RESP1_READY : RESP0_READY) begin
            RESP0_VALID <= 1'b0;
            RESP1_VALID <= 1'b0;
            BUSY        <= 1'b0;
            ptr         <= ~owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler: directed ops on both ports, a table-driven fpu
// stand-in, and a scoreboard monitor that checks owner, result and latency.
module tb_fpu_op_scheduler;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        rv   [2];
  logic [31:0] rd1  [2];
  logic [31:0] rd2  [2];
  logic [31:0] rd3  [2];
  logic [4:0]  rsel [2];
  logic        resp_rdy [2];

  logic        REQ0_READY, REQ1_READY;
  logic        RESP0_VALID, RESP1_VALID;
  logic [31:0] RESP_RESULT;
  logic [31:0] FPU_DATA1, FPU_DATA2, FPU_DATA3;
  logic [4:0]  FPU_SELECT;
  logic [31:0] FPU_RESULT;
  logic        BUSY;
  logic [1:0]  dbg_state;

  fpu_op_scheduler dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ0_VALID  (rv[0]),
    .REQ0_READY  (REQ0_READY),
    .REQ0_DATA1  (rd1[0]),
    .REQ0_DATA2  (rd2[0]),
    .REQ0_DATA3  (rd3[0]),
    .REQ0_SELECT (rsel[0]),
    .REQ1_VALID  (rv[1]),
    .REQ1_READY  (REQ1_READY),
    .REQ1_DATA1  (rd1[1]),
    .REQ1_DATA2  (rd2[1]),
    .REQ1_DATA3  (rd3[1]),
    .REQ1_SELECT (rsel[1]),
    .RESP0_VALID (RESP0_VALID),
    .RESP0_READY (resp_rdy[0]),
    .RESP1_VALID (RESP1_VALID),
    .RESP1_READY (resp_rdy[1]),
    .RESP_RESULT (RESP_RESULT),
    .FPU_DATA1   (FPU_DATA1),
    .FPU_DATA2   (FPU_DATA2),
    .FPU_DATA3   (FPU_DATA3),
    .FPU_SELECT  (FPU_SELECT),
    .FPU_RESULT  (FPU_RESULT),
    .BUSY        (BUSY),
    .dbg_state   (dbg_state)
  );

  // ---------------- fpu stand-in: hand-computed IEEE-754 single results -----
  function automatic logic [31:0] fpu_model(input logic [4:0] s,
                                            input logic [31:0] a, b, c);
    logic [31:0] r;
    r = 32'hBAD0BAD0;
    if (s > 5'd20) begin
      r = 32'h0;
    end else begin
      case ({s, a, b, c})
        {5'd1,  32'h3f800000, 32'h40000000, 32'h0}:        r = 32'h40400000; // 1+2
        {5'd3,  32'h40000000, 32'h40400000, 32'h0}:        r = 32'h40C00000; // 2*3
        {5'd4,  32'h40C00000, 32'h40000000, 32'h0}:        r = 32'h40400000; // 6/2
        {5'd14, 32'h40000000, 32'h40400000, 32'h3f800000}: r = 32'h40E00000; // 2*3+1
        {5'd17, 32'h40000000, 32'h40400000, 32'h3f800000}: r = 32'hC0A00000; // -(2*3)+1
        {5'd1,  32'h3f800000, 32'h3f800000, 32'h0}:        r = 32'h40000000; // 1+1
        {5'd1,  32'h40800000, 32'h40800000, 32'h0}:        r = 32'h41000000; // 4+4
        {5'd1,  32'h40000000, 32'h40000000, 32'h0}:        r = 32'h40800000; // 2+2
        {5'd1,  32'h40400000, 32'h40000000, 32'h0}:        r = 32'h40A00000; // 3+2
        {5'd3,  32'h3f800000, 32'h3f800000, 32'h0}:        r = 32'h3f800000; // 1*1
        {5'd3,  32'h40400000, 32'h40000000, 32'h0}:        r = 32'h40C00000; // 3*2
        {5'd3,  32'h40400000, 32'h40400000, 32'h0}:        r = 32'h41100000; // 3*3
        {5'd3,  32'h40800000, 32'h40800000, 32'h0}:        r = 32'h41800000; // 4*4
        default: r = 32'hBAD0BAD0;
      endcase
    end
    return r;
  endfunction

  assign FPU_RESULT = fpu_model(FPU_SELECT, FPU_DATA1, FPU_DATA2, FPU_DATA3);

  // Expected latency class of an op code.
  function automatic int exp_lat(input logic [4:0] s);
    if (s == 5'd3) return 3;
    if (s == 5'd4) return 8;
    if (s >= 5'd14 && s <= 5'd17) return 4;
    return 1;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int          port;
    logic [31:0] res;
    logic [4:0]  sel;
    logic [31:0] d1;
    int unsigned due;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver ----------------
  task automatic issue(input int p, input logic [4:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] r,
                       input int stall);
    exp_t e;
    bit   ok;
    logic rdy;
    ok = 0;
    @(negedge CLK);
    rv[p] = 1'b1; rsel[p] = s; rd1[p] = a; rd2[p] = b; rd3[p] = c;
    for (int t = 0; t < 200; t++) begin
      #1;
      rdy = (p == 1) ? REQ1_READY : REQ0_READY;
      if (rdy) begin
        ok = 1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) begin
      e.port = p; e.res = r; e.sel = s; e.d1 = a; e.stall = stall;
      e.due  = cyc + 1 + exp_lat(s);
      exp_q.push_back(e);
      grant_log.push_back(p);
      @(posedge CLK);
      #1;
    end else begin
      check("accept_timeout", 32'(rdy), 32'd1);
    end
    rv[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !BUSY) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  // ---------------- monitor ----------------
  logic        prev_busy = 1'b0;
  logic [31:0] prev_d1   = 32'd0;
  logic [4:0]  prev_sel  = 5'd0;

  // Checks invariants every cycle and pops/compares on each new response.
  initial begin
    exp_t        e;
    logic [31:0] hold_res;
    int          other;
    resp_rdy[0] = 1'b0;
    resp_rdy[1] = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        check("ready_excl", 32'(REQ0_READY & REQ1_READY), 32'd0);
        check("resp_excl",  32'(RESP0_VALID & RESP1_VALID), 32'd0);
        check("busy_ready", 32'(BUSY & (REQ0_READY | REQ1_READY)), 32'd0);
        check("idle_resp",  32'(~BUSY & (RESP0_VALID | RESP1_VALID)), 32'd0);
        if (prev_busy && BUSY) begin
          check("fpu_hold_d1",  FPU_DATA1, prev_d1);
          check("fpu_hold_sel", 32'(FPU_SELECT), 32'(prev_sel));
        end
        prev_busy = BUSY; prev_d1 = FPU_DATA1; prev_sel = FPU_SELECT;
        if (RESP0_VALID || RESP1_VALID) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'(RESP0_VALID | RESP1_VALID), 32'd0);
            resp_rdy[0] = 1'b1; resp_rdy[1] = 1'b1;
            @(posedge CLK); #1;
            resp_rdy[0] = 1'b0; resp_rdy[1] = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check("resp_port", 32'(RESP1_VALID), 32'(e.port));
            check("resp_result", RESP_RESULT, e.res);
            check("resp_latency", cyc, e.due);
            check("fpu_sel_kept", 32'(FPU_SELECT), 32'(e.sel));
            check("fpu_d1_kept", FPU_DATA1, e.d1);
            other = 1 - e.port;
            hold_res = RESP_RESULT;
            resp_rdy[other] = 1'b1;
            for (int k = 0; k < e.stall; k++) begin
              @(negedge CLK);
              check("stall_valid", 32'(e.port == 1 ? RESP1_VALID : RESP0_VALID), 32'd1);
              check("stall_result", RESP_RESULT, hold_res);
              check("stall_no_accept", 32'(REQ0_READY | REQ1_READY), 32'd0);
            end
            resp_rdy[other]  = 1'b0;
            resp_rdy[e.port] = 1'b1;
            @(posedge CLK); #1;
            resp_rdy[e.port] = 1'b0;
            prev_busy = 1'b0;
          end
        end
      end else begin
        prev_busy = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got %0d cycles expected fewer", cyc);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    RESET = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; rd1[p] = '0; rd2[p] = '0; rd3[p] = '0; rsel[p] = '0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_result",  RESP_RESULT, 32'd0);
    check("rst_fpu_d1",  FPU_DATA1, 32'd0);
    check("rst_fpu_d2",  FPU_DATA2, 32'd0);
    check("rst_fpu_d3",  FPU_DATA3, 32'd0);
    check("rst_fpu_sel", 32'(FPU_SELECT), 32'd0);
    check("rst_busy",    32'(BUSY), 32'd0);
    check("rst_resp",    32'(RESP0_VALID | RESP1_VALID), 32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);

    // Both valid from reset: port0 FMUL wins, then port1 FDIV.
    base = grant_log.size();
    fork
      issue(0, 5'd3, 32'h40000000, 32'h40400000, 32'h0, 32'h40C00000, 0);
      issue(1, 5'd4, 32'h40C00000, 32'h40000000, 32'h0, 32'h40400000, 0);
    join
    wait_idle();
    check("t2_grant0", 32'(grant_log[base]),     32'd0);
    check("t2_grant1", 32'(grant_log[base + 1]), 32'd1);

    // Single FADD on port0 (PTR now 0 after port1 completed).
    issue(0, 5'd1, 32'h3f800000, 32'h40000000, 32'h0, 32'h40400000, 0);
    wait_idle();

    // Contention, 4 ops each; PTR is 1 after the port0 FADD.
    base = grant_log.size();
    fork
      begin
        issue(0, 5'd1, 32'h3f800000, 32'h3f800000, 32'h0, 32'h40000000, 0);
        issue(0, 5'd1, 32'h40800000, 32'h40800000, 32'h0, 32'h41000000, 0);
        issue(0, 5'd1, 32'h40000000, 32'h40000000, 32'h0, 32'h40800000, 0);
        issue(0, 5'd1, 32'h40400000, 32'h40000000, 32'h0, 32'h40A00000, 0);
      end
      begin
        issue(1, 5'd3, 32'h3f800000, 32'h3f800000, 32'h0, 32'h3f800000, 0);
        issue(1, 5'd3, 32'h40400000, 32'h40000000, 32'h0, 32'h40C00000, 0);
        issue(1, 5'd3, 32'h40400000, 32'h40400000, 32'h0, 32'h41100000, 0);
        issue(1, 5'd3, 32'h40800000, 32'h40800000, 32'h0, 32'h41800000, 0);
      end
    join
    wait_idle();
    for (int i = 0; i < 8; i++)
      check("t3_alternate", 32'(grant_log[base + i]), (i % 2 == 0) ? 32'd1 : 32'd0);

    // Boundaries: undefined select on port0 (basic latency, result 0),
    // top of the fused range on port1.
    issue(0, 5'd21, 32'h12345678, 32'h9abcdef0, 32'h0, 32'h0, 0);
    wait_idle();
    issue(1, 5'd17, 32'h40000000, 32'h40400000, 32'h3f800000, 32'hC0A00000, 0);
    wait_idle();

    // Response stall on port1 FMADD while port0 waits with VALID held.
    fork
      issue(1, 5'd14, 32'h40000000, 32'h40400000, 32'h3f800000, 32'h40E00000, 5);
      begin
        repeat (3) @(negedge CLK);
        issue(0, 5'd1, 32'h3f800000, 32'h40000000, 32'h0, 32'h40400000, 0);
      end
    join
    wait_idle();

    // Reset during FDIV on port1 (PTR is 1 here); op must vanish.
    issue(1, 5'd4, 32'h40C00000, 32'h40000000, 32'h0, 32'h40400000, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("mid_rst_busy",   32'(BUSY), 32'd0);
    check("mid_rst_resp",   32'(RESP0_VALID | RESP1_VALID), 32'd0);
    check("mid_rst_result", RESP_RESULT, 32'd0);
    check("mid_rst_fpu_d1", FPU_DATA1, 32'd0);
    check("mid_rst_fpu_sel", 32'(FPU_SELECT), 32'd0);
    check("mid_rst_state",  32'(dbg_state), 32'd0);
    repeat (12) @(negedge CLK);
    base = grant_log.size();
    fork
      issue(0, 5'd1, 32'h3f800000, 32'h3f800000, 32'h0, 32'h40000000, 0);
      issue(1, 5'd3, 32'h3f800000, 32'h3f800000, 32'h0, 32'h3f800000, 0);
    join
    wait_idle();
    check("t5_ptr_reset", 32'(grant_log[base]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
